// File: rtl/wm_pkg.sv
// wm_pkg: machine states, programme field layout and field helpers shared by the washer controllers
package wm_pkg;
  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;
  localparam int MSG_W = 26;
  localparam int FIELDS = 8;
  localparam int FLD_LO [FIELDS] = '{0, 3, 6, 10, 13, 16, 19, 23};
  localparam int FLD_HI [FIELDS] = '{2, 5, 9, 12, 15, 18, 22, 25};
  // Top field's mask relies on 2^26 wrapping to zero in 26 bits.
  function automatic logic [MSG_W-1:0] fld_mask(int i);
    return (MSG_W'(1) << (FLD_HI[i] + 1)) - (MSG_W'(1) << FLD_LO[i]);
  endfunction
  function automatic logic [2:0] top_fld(logic [MSG_W-1:0] m);
    top_fld = '0;
    for (int i = 0; i < FIELDS; i++) if ((m & fld_mask(i)) != '0) top_fld = 3'(i);
  endfunction
  // The chosen field is nonzero, so subtracting its LSB never borrows out of it.
  function automatic logic [MSG_W-1:0] dec_top(logic [MSG_W-1:0] m);
    return m - (MSG_W'(1) << FLD_LO[top_fld(m)]);
  endfunction
endpackage

// File: rtl/wash_sequencer_if.sv
// wash_sequencer_if: keys, door sensor, programme and status lines of the washer sequencer
interface wash_sequencer_if;
  logic power_key, set_key, start_key, pause_key, door_open;
  logic [wm_pkg::MSG_W-1:0] source, msg;
  logic [2:0] state, active_fld;
  logic buzzer, done;
  modport master (
    output power_key, set_key, start_key, pause_key, door_open, source,
    input  state, msg, active_fld, buzzer, done
  );
  modport slave (
    input  power_key, set_key, start_key, pause_key, door_open, source,
    output state, msg, active_fld, buzzer, done
  );
endinterface

// File: rtl/wm_tick_prescaler.sv
// wm_tick_prescaler: divides cp down to one time-unit tick while enabled; frozen otherwise
module wm_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic cp,
  input  logic reset,
  input  logic run_en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = run_en && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge cp or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run_en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: washer main FSM; loads the programme and counts its fields down per time unit
module wash_sequencer
  import wm_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int FINISH_UNITS = 3
) (
  input logic cp,
  input logic reset,
  wash_sequencer_if.slave bus
);
  localparam int FW = FINISH_UNITS > 1 ? $clog2(FINISH_UNITS) : 1;
  state_t st, nx;
  logic [MSG_W-1:0] msg, msg_n;
  logic [FW-1:0] fin, fin_n;
  logic [2:0] act;
  logic buz, dn, tick, clr;
  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .cp(cp),
    .reset(reset),
    .run_en(st == ST_RUN || st == ST_FINISH),
    .clr(clr),
    .tick(tick)
  );
  always_ff @(posedge cp or posedge reset)
    if (reset) begin
      st  <= ST_SHUTDOWN;
      msg <= '0;
      act <= '0;
      buz <= 1'b0;
      dn  <= 1'b0;
      fin <= '0;
    end else begin
      st  <= nx;
      msg <= msg_n;
      act <= top_fld(msg_n);
      buz <= nx == ST_FINISH;
      dn  <= nx == ST_FINISH && st != ST_FINISH;
      fin <= fin_n;
    end
  // Power beats door, door beats pause, pause beats start/set, everything beats the tick.
  always_comb begin
    nx = st;
    msg_n = msg;
    fin_n = fin;
    if (bus.power_key) begin
      nx = st == ST_SHUTDOWN ? ST_BEGIN : ST_SHUTDOWN;
      msg_n = '0;
    end else case (st)
      ST_BEGIN: nx = bus.set_key ? ST_SET : st;
      ST_SET: if (bus.start_key && bus.source != '0) begin
        nx = ST_RUN;
        msg_n = bus.source;
      end
      ST_RUN: if (bus.door_open) nx = ST_ERROR;
        else if (bus.pause_key) nx = ST_PAUSE;
        else if (tick) begin
          msg_n = dec_top(msg);
          nx = msg_n == '0 ? ST_FINISH : ST_RUN;
        end
      ST_PAUSE: nx = bus.door_open ? ST_ERROR : bus.start_key ? ST_RUN : st;
      ST_ERROR: nx = bus.start_key && !bus.door_open ? ST_RUN : st;
      ST_FINISH: if (bus.set_key) nx = ST_SET;
        else if (tick) begin
          fin_n = fin + 1'b1;
          nx = fin == FW'(FINISH_UNITS - 1) ? ST_BEGIN : st;
        end
      default: nx = ST_SHUTDOWN;
    endcase
    if (nx == ST_FINISH && st != ST_FINISH) fin_n = '0;
    clr = nx != st && (nx == ST_SHUTDOWN || nx == ST_FINISH || (nx == ST_RUN && st == ST_SET));
  end
  assign bus.state = st;
  assign bus.msg = msg;
  assign bus.active_fld = act;
  assign bus.buzzer = buz;
  assign bus.done = dn;
endmodule
